// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - clear-FSM state type and default sizing for reg_file_mp
package reg_file_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// rtl/reg_file_clr_ctrl.sv - sequential clear FSM, zeroes one entry per cycle from 0 upward
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Last index stops the sweep so non-power-of-two depths never wrap.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next state: a request is only honoured from IDLE, so a repeat request mid-clear is ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // State and pointer registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_we   = clr_busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 1W/2R register file with sequential clear; REG_FILE_BYPASS_EN forwards same-cycle writes to reads
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_accept;
  logic [DATA_W-1:0] rd0_word, rd1_word;

  logic [DATA_W-1:0] rd0_data_q, rd0_data_d;
  logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
  logic              rd0_valid_q, rd0_valid_d;
  logic              rd1_valid_q, rd1_valid_d;

  reg_file_clr_ctrl #(
    .DEPTH (DEPTH)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write lands only when idle and the address names a real entry; busy writes are dropped.
  always_comb begin
    wr_accept = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && !clr_busy && (w_addr == ADDR_W'(i))) begin
        wr_accept = 1'b1;
      end
    end
  end

  // Next entry contents: clear sweep zeroes its entry, otherwise an accepted write updates.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clr_we && (clr_addr == ADDR_W'(i))) begin
        mem_d[i] = '0;
      end else if (wr_accept && (w_addr == ADDR_W'(i))) begin
        mem_d[i] = w_data;
      end
    end
  end

  // Storage array; every entry returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read mux per port; addresses past the last entry match nothing and return zero.
  always_comb begin
    rd0_word = '0;
    rd1_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd0_addr == ADDR_W'(i)) begin
        rd0_word = mem_q[i];
      end
      if (rd1_addr == ADDR_W'(i)) begin
        rd1_word = mem_q[i];
      end
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_accept && (rd0_addr == w_addr)) begin
      rd0_word = w_data;
    end
    if (wr_accept && (rd1_addr == w_addr)) begin
      rd1_word = w_data;
    end
`endif
  end

  // Read result capture: data holds while a port is not enabled, valid tracks the enable.
  always_comb begin
    rd0_data_d  = rd0_en ? rd0_word : rd0_data_q;
    rd1_data_d  = rd1_en ? rd1_word : rd1_data_q;
    rd0_valid_d = rd0_en;
    rd1_valid_d = rd1_en;
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
    end else begin
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_valid_q <= rd1_valid_d;
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd1_data  = rd1_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_valid = rd1_valid_q;

endmodule
